// File: rtl/bf16_to_int18_pipe.sv
// BF16 to signed 18-bit fixed-point converter (FRAC_BITS fractional bits), 2-stage valid/ready pipeline.
// Optional macro BF16_TO_INT_ROUND_NEAREST_EN: right shifts round to nearest-even instead of truncating.
module bf16_to_int18_pipe #(
    parameter int FRAC_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_bf16,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] out_data,
    output logic        out_sat,
    output logic        sat_sticky,
    input  logic        sat_clear
);

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_t;

    logic              w_s1_en;
    logic              w_s2_en;

    logic              r_s1_valid;
    logic              r_s1_sign;
    logic [7:0]        r_s1_sig;
    logic signed [9:0] r_s1_sh;
    cls_t              r_s1_cls;

    logic              r_s2_valid;
    logic [17:0]       r_out_data;
    logic              r_out_sat;
    logic              r_sat_sticky;

    logic [7:0]        w_exp;
    logic [6:0]        w_mant;
    logic signed [9:0] w_sh;
    cls_t              w_cls;

    assign w_s2_en  = !r_s2_valid || out_ready;
    assign w_s1_en  = !r_s1_valid || w_s2_en;
    assign in_ready = w_s1_en;

    // Stage 1: decode exponent into a signed left-shift amount relative to the 8-bit significand.
    assign w_exp  = in_bf16[14:7];
    assign w_mant = in_bf16[6:0];
    assign w_sh   = $signed({2'b00, w_exp}) - 10'sd134 + $signed(10'(FRAC_BITS));

    always_comb begin
        w_cls = CLS_NORM;
        if (w_exp == 8'h00) begin
            w_cls = CLS_ZERO;
        end else if (w_exp == 8'hFF) begin
            w_cls = (w_mant == 7'd0) ? CLS_INF : CLS_NAN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_sig   <= '0;
            r_s1_sh    <= '0;
            r_s1_cls   <= CLS_ZERO;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= in_bf16[15];
                r_s1_sig  <= {1'b1, w_mant};
                r_s1_sh   <= w_sh;
                r_s1_cls  <= w_cls;
            end
        end
    end

    // Stage 2: shift/saturate. Right shifts go through a 16-bit window so the
    // shifted-out bits (guard + sticky) land in the low byte.
    logic signed [9:0] w_nsh;
    logic [15:0]       w_ext;
    logic [17:0]       w_mag;
    logic              w_round_up;
    logic              w_ovf;
    logic [17:0]       w_signed_mag;
    logic [17:0]       w_sat_val;
    logic [17:0]       w_s2_data;
    logic              w_s2_sat;

    always_comb begin
        w_nsh      = -r_s1_sh;
        w_ext      = '0;
        w_mag      = '0;
        w_round_up = 1'b0;
        w_ovf      = 1'b0;
        if (r_s1_sh >= 10'sd10) begin
            w_ovf = 1'b1;
        end else if (r_s1_sh >= 10'sd0) begin
            w_mag = {10'd0, r_s1_sig} << r_s1_sh[3:0];
        end else begin
            if (w_nsh <= 10'sd8) begin
                w_ext = {r_s1_sig, 8'd0} >> w_nsh[3:0];
            end
`ifdef BF16_TO_INT_ROUND_NEAREST_EN
            w_round_up = w_ext[7] & ((|w_ext[6:0]) | w_ext[8]);
`endif
            // Magnitude here is at most 128 after rounding, so no carry can reach the saturation limit.
            w_mag = ({2'b00, w_ext} >> 8) + {17'd0, w_round_up};
        end
    end

    assign w_signed_mag = r_s1_sign ? (18'd0 - w_mag) : w_mag;
    assign w_sat_val    = r_s1_sign ? 18'h20000 : 18'h1FFFF;

    always_comb begin
        w_s2_data = '0;
        w_s2_sat  = 1'b0;
        case (r_s1_cls)
            CLS_ZERO: begin
                w_s2_data = '0;
                w_s2_sat  = 1'b0;
            end
            CLS_NAN: begin
                w_s2_data = '0;
                w_s2_sat  = 1'b1;
            end
            CLS_INF: begin
                w_s2_data = w_sat_val;
                w_s2_sat  = 1'b1;
            end
            default: begin
                w_s2_data = w_ovf ? w_sat_val : w_signed_mag;
                w_s2_sat  = w_ovf;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_s2_data;
                r_out_sat  <= w_s2_sat;
            end
        end
    end

    // A saturating transfer beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_sticky <= 1'b0;
        end else if (r_s2_valid && out_ready && r_out_sat) begin
            r_sat_sticky <= 1'b1;
        end else if (sat_clear) begin
            r_sat_sticky <= 1'b0;
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_data   = r_out_data;
    assign out_sat    = r_out_sat;
    assign sat_sticky = r_sat_sticky;

endmodule

// File: tb/tb_bf16_to_int18_pipe.sv
// Directed bench for bf16_to_int18_pipe (FRAC_BITS=8): vector table plus handshake/reset/sticky sequences.
module tb_bf16_to_int18_pipe;

`ifdef BF16_TO_INT_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_bf16 = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [17:0] out_data;
    logic        out_sat;
    logic        sat_sticky;
    logic        sat_clear = 1'b0;

    bf16_to_int18_pipe #(.FRAC_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bf16    (in_bf16),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .sat_sticky (sat_sticky),
        .sat_clear  (sat_clear)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [17:0] s18(input int v);
        return v[17:0];
    endfunction

    typedef struct {
        logic [15:0] bf;
        logic [17:0] exp_data;
        logic        exp_sat;
    } vec_t;

    logic [17:0] got_q[$];
    bit          mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) got_q.push_back(out_data);
    end

    vec_t        vecs[18];
    logic [15:0] bp_in[5];
    logic [17:0] bp_exp[5];

    initial begin
        int cyc;
        int idx;
        int first_stall;
        bit held_vld;
        logic [17:0] held_data;
        logic        held_sat;

        vecs[0]  = '{16'h3F80, s18(256),     1'b0};
        vecs[1]  = '{16'hC020, s18(-640),    1'b0};
        vecs[2]  = '{16'h3B80, s18(1),       1'b0};
        vecs[3]  = '{16'h3B00, s18(0),       1'b0};
        vecs[4]  = '{16'h3BC0, s18(RNE ? 2 : 1),   1'b0};
        vecs[5]  = '{16'hBBC0, s18(RNE ? -2 : -1), 1'b0};
        vecs[6]  = '{16'h3C20, s18(2),       1'b0};
        vecs[7]  = '{16'h0040, s18(0),       1'b0};
        vecs[8]  = '{16'h43FF, s18(130560),  1'b0};
        vecs[9]  = '{16'hC3FF, s18(-130560), 1'b0};
        vecs[10] = '{16'h4400, s18(131071),  1'b1};
        vecs[11] = '{16'h4780, s18(131071),  1'b1};
        vecs[12] = '{16'hFF80, s18(-131072), 1'b1};
        vecs[13] = '{16'h7FC0, s18(0),       1'b1};
        vecs[14] = '{16'h7F80, s18(131071),  1'b1};
        vecs[15] = '{16'hC700, s18(-131072), 1'b1};
        vecs[16] = '{16'h3A00, s18(0),       1'b0};
        vecs[17] = '{16'h8000, s18(0),       1'b0};

        bp_in[0] = 16'h3F80; bp_exp[0] = s18(256);
        bp_in[1] = 16'h4000; bp_exp[1] = s18(512);
        bp_in[2] = 16'hC000; bp_exp[2] = s18(-512);
        bp_in[3] = 16'h3F00; bp_exp[3] = s18(128);
        bp_in[4] = 16'h4040; bp_exp[4] = s18(768);

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_sat", 32'(out_sat), 0);
        chk("rst_sticky", 32'(sat_sticky), 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        // Vector table, one word at a time, out_ready high
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_bf16  = vecs[i].bf;
            @(posedge clk); #1;
            in_valid = 1'b0;
            cyc = 1;
            while (!out_valid && cyc < 8) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk($sformatf("lat_%h", vecs[i].bf), cyc, 2);
            chk($sformatf("data_%h", vecs[i].bf), 32'(out_data), 32'(vecs[i].exp_data));
            chk($sformatf("sat_%h", vecs[i].bf), 32'(out_sat), 32'(vecs[i].exp_sat));
        end
        chk("sticky_after_sat", 32'(sat_sticky), 1);

        // sat_clear alone clears
        @(posedge clk); #1;
        sat_clear = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        chk("sticky_cleared", 32'(sat_sticky), 0);

        // Backpressure: 5 back-to-back words, out_ready low for 4 cycles
        got_q.delete();
        mon_en      = 1'b1;
        idx         = 0;
        cyc         = 0;
        first_stall = -1;
        held_vld    = 1'b0;
        held_data   = '0;
        held_sat    = 1'b0;
        while ((idx < 5 || got_q.size() < 5) && cyc < 40) begin
            @(posedge clk); #1;
            out_ready = (cyc >= 4);
            in_valid  = (idx < 5);
            if (idx < 5) in_bf16 = bp_in[idx];
            @(negedge clk);
            if (in_valid && !in_ready && first_stall < 0) first_stall = idx;
            if (in_valid && in_ready) idx++;
            if (out_valid && !out_ready) begin
                if (held_vld) begin
                    chk("bp_hold_data", 32'(out_data), 32'(held_data));
                    chk("bp_hold_sat", 32'(out_sat), 32'(held_sat));
                end
                held_data = out_data;
                held_sat  = out_sat;
                held_vld  = 1'b1;
            end
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 mon_en = 1'b0;
        chk("bp_stall_after", first_stall, 2);
        chk("bp_count", got_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) chk($sformatf("bp_word%0d", i), 32'(got_q[i]), 32'(bp_exp[i]));
        end

        // Clear/set collision: saturating transfer and sat_clear in the same cycle
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_bf16  = 16'h4780;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("coll_pre_valid", 32'(out_valid), 1);
        chk("coll_pre_sticky", 32'(sat_sticky), 0);
        sat_clear = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        chk("coll_sticky", 32'(sat_sticky), 1);
        chk("coll_drained", 32'(out_valid), 0);

        // Reset with both stages full
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_bf16  = 16'h4780;
        @(posedge clk); #1;
        in_bf16  = 16'h3F80;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_pre_valid", 32'(out_valid), 1);
        chk("mid_pre_in_ready", 32'(in_ready), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_out_valid", 32'(out_valid), 0);
        chk("mid_sticky", 32'(sat_sticky), 0);
        chk("mid_out_data", 32'(out_data), 0);
        chk("mid_in_ready", 32'(in_ready), 1);
        got_q.delete();
        mon_en    = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 mon_en = 1'b0;
        chk("mid_no_stale", got_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bf16_to_int18_pipe.md
Name: bf16_to_int18_pipe

Overview:
- Two-stage pipelined converter from BF16 to signed 18-bit fixed-point with FRAC_BITS fractional bits.
- Inverse of the accumulator normaliser: it feeds BF16 operands (weights, activations, host-loaded data) into the integer MAC array's accumulator domain.
- Uses valid/ready streaming on both sides, full throughput of one conversion per cycle, plus a sticky saturation flag.

Parameters:
- FRAC_BITS, 8, number of fractional bits in the int18 output (value = out_data / 2^FRAC_BITS); legal range 0..16.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  converter can accept input this cycle
- in_bf16  in  16  BF16 operand {sign, exp[7:0], mant[6:0]}
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  18  signed fixed-point result
- out_sat  out  1  per-result flag: this result was saturated or came from NaN
- sat_sticky  out  1  OR of all out_sat since reset or last sat_clear
- sat_clear  in  1  clears sat_sticky

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_sat=0, sat_sticky=0. Data in flight is discarded. in_ready=1 in the first cycle after reset.
- Pipeline enables:
  - s2_en = !s2_valid | out_ready
  - s1_en = !s1_valid | s2_en
  - in_ready = s1_en (combinational)
  - An input transfer occurs when in_valid & in_ready.
  - Latency is 2 cycles from the accepted input to out_valid when out_ready is held high. Throughput is 1 per cycle.
- Stall rule: while out_valid & !out_ready, out_data and out_sat hold stable and no stage advances.
- Stage 1 (decode), registered:
  - sign.
  - sig = {1, mant} (8 bits).
  - sh = exp - 134 + FRAC_BITS, signed 10-bit.
  - class: ZERO when exp==0 (zero or denormal; denormals flush to zero). INF when exp==FF and mant==0. NAN when exp==FF and mant!=0. NORM otherwise.
- Stage 2 (shift/saturate), registered:
  - NORM, sh>=10: saturate, out_sat=1.
  - NORM, 0<=sh<=9: mag = sig << sh.
  - NORM, sh<0: mag = sig >> -sh, with rounding per the optional feature. If -sh>=9, mag=0 before rounding.
  - ZERO: out_data=0, out_sat=0. Negative zero also gives 0.
  - INF, or saturate: positive gives 131071 (0x1FFFF); negative gives -131072 (0x20000); out_sat=1.
  - NAN: out_data=0, out_sat=1.
  - Final: out_data = sign ? -mag : mag. No overflow is possible for NORM with sh<=9, since 255<<9 = 130560.
- sat_sticky:
  - Set on any output transfer (out_valid & out_ready) with out_sat=1.
  - sat_clear=1 clears it.
  - If sat_clear and a saturating transfer occur in the same cycle, set wins (sat_sticky=1).

Optional Feature:
- Macro: BF16_TO_INT_ROUND_NEAREST_EN.
- Defined: the right-shift path rounds to nearest, ties to even, using guard and sticky bits of the shifted-out portion. If rounding carries mag past 131071, the result saturates with out_sat=1; for FRAC_BITS<=16 this cannot occur.
- Not defined: right shift truncates the magnitude, i.e. rounds toward zero. Positive and negative results are symmetric.
- Latency and handshake are identical in both builds.

Test Plan (FRAC_BITS=8 for all; out_ready=1 unless stated):
- Basic values: in 0x3F80 (1.0) -> out_data=256, out_sat=0, two cycles later. In 0xC020 (-2.5) -> -640 (0x3FD80).
- Saturation and specials: 0x4780 (65536.0) -> 131071, out_sat=1, sat_stickyolarity=1. 0xFF80 (-inf) -> -131072, out_sat=1. 0x7FC0 (NaN) -> 0, out_sat=1. Then pulse sat_clear -> sat_sticky=0.
- Small values and rounding:
  - 0x3B80 (2^-8) -> 1.
  - 0x3B00 (0.5 LSB) -> 0 in both builds.
  - 0x3BC0 (1.5 LSB) -> 1 truncate / 2 RNE.
  - 0x3C20 (2.5 LSB) -> 2 in both builds.
  - 0x0040 (denormal) -> 0, out_sat=0.
- Backpressure: stream 5 back-to-back inputs, hold out_ready=0 for 4 cycles. Required: in_ready drops after 2 accepted words, out_data holds stable, and all 5 results emerge in order with no loss or duplication.
- Reset mid-stream: assert rst with both stages valid -> out_valid=0 on the next cycle, sat_sticky=0, and no stale result emerges afterward.
- Clear/set collision: sat_clear=1 in the same cycle as a saturating output transfer -> sat_sticky=1.
